// File: rtl/lane_sweep_controller.sv
// Lane sweep sequencer for a 5x5 lane-wise state array: one READ/WRITE pair per lane,
// 25 lanes per round, ROUNDS rounds per start, with permuted (i, j) coordinates.
module lane_sweep_controller #(
  parameter int ROUNDS  = 24,
  parameter int ROUND_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic               wr_en,
  output logic [4:0]         lane_num,
  output logic [2:0]         i,
  output logic [2:0]         j,
  output logic [ROUND_W-1:0] round,
  output logic               last_lane,
  output logic [1:0]         dbg_state
);

  // Handshake: start is a request sampled only in IDLE (no ready; ignored elsewhere).
  // hold is a stall: while high in READ/WRITE the state and counters stay put and the
  // strobe of the current cycle is suppressed; the pair completes once hold drops.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);
  localparam logic [4:0]         LAST_LANE  = 5'd24;

  state_t     state;
  logic [2:0] x;
  logic [2:0] y;
  logic [2:0] x_nxt;
  logic [2:0] y_nxt;
  logic       rd_q;
  logic       wr_q;

  // Coordinate permutation (v + 3) mod 5 without a divider.
  function automatic logic [2:0] map3(input logic [2:0] v);
    return (v >= 3'd2) ? (v - 3'd2) : (v + 3'd3);
  endfunction

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (x == 3'd4) begin
      x_nxt = 3'd0;
      y_nxt = (y == 3'd4) ? 3'd0 : (y + 3'd1);
    end else begin
      x_nxt = x + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lane_num  <= 5'd0;
      round     <= '0;
      x         <= 3'd0;
      y         <= 3'd0;
      i         <= 3'd0;
      j         <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      last_lane <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_READ;
            lane_num  <= 5'd0;
            round     <= '0;
            x         <= 3'd0;
            y         <= 3'd0;
            i         <= map3(3'd0);
            j         <= map3(3'd0);
            busy      <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b0;
            last_lane <= 1'b0;
          end
        end

        S_READ: begin
          if (!hold) begin
            state <= S_WRITE;
            rd_q  <= 1'b0;
            wr_q  <= 1'b1;
          end
        end

        S_WRITE: begin
          if (!hold) begin
            if (lane_num != LAST_LANE) begin
              state     <= S_READ;
              lane_num  <= lane_num + 5'd1;
              x         <= x_nxt;
              y         <= y_nxt;
              i         <= map3(x_nxt);
              j         <= map3(y_nxt);
              last_lane <= (lane_num == LAST_LANE - 5'd1);
              rd_q      <= 1'b1;
              wr_q      <= 1'b0;
            end else if (round != LAST_ROUND) begin
              // Round boundary: restart the lane walk and both coordinate counters.
              state     <= S_READ;
              lane_num  <= 5'd0;
              round     <= round + ROUND_W'(1);
              x         <= 3'd0;
              y         <= 3'd0;
              i         <= map3(3'd0);
              j         <= map3(3'd0);
              last_lane <= 1'b0;
              rd_q      <= 1'b1;
              wr_q      <= 1'b0;
            end else begin
              // Final lane of final round; round is left at ROUNDS-1 for observation.
              state     <= S_DONE;
              lane_num  <= 5'd0;
              x         <= 3'd0;
              y         <= 3'd0;
              i         <= 3'd0;
              j         <= 3'd0;
              last_lane <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              rd_q      <= 1'b0;
              wr_q      <= 1'b0;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are the registered phase flags gated by hold within the same cycle.
  assign rd_en     = rd_q & ~hold;
  assign wr_en     = wr_q & ~hold;
  assign dbg_state = state;

endmodule

// File: tb/tb_lane_sweep_controller.sv
// Directed bench for lane_sweep_controller: ROUNDS=1 and ROUNDS=2 instances on one clock.
module tb_lane_sweep_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       hold;

  logic       busy1, done1, rd1, wr1, last1;
  logic [4:0] lane1;
  logic [2:0] i1, j1;
  logic [4:0] round1;
  logic [1:0] st1;

  logic       busy2, done2, rd2, wr2, last2;
  logic [4:0] lane2;
  logic [2:0] i2, j2;
  logic [4:0] round2;
  logic [1:0] st2;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int   cyc;
    logic rd;
    logic wr;
    logic busy;
    logic done;
    logic last;
    int   lane;
    int   ci;
    int   cj;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  lane_sweep_controller #(.ROUNDS(1), .ROUND_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .busy(busy1), .done(done1), .rd_en(rd1), .wr_en(wr1),
    .lane_num(lane1), .i(i1), .j(j1), .round(round1),
    .last_lane(last1), .dbg_state(st1)
  );

  lane_sweep_controller #(.ROUNDS(2), .ROUND_W(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .busy(busy2), .done(done2), .rd_en(rd2), .wr_en(wr2),
    .lane_num(lane2), .i(i2), .j(j2), .round(round2),
    .last_lane(last2), .dbg_state(st2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance into the next cycle with the given inputs, then settle for sampling.
  task automatic step(input logic s, input logic h);
    @(posedge clk);
    #1;
    start = s;
    hold  = h;
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  task automatic check_all_zero1(input string tag);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_rd"}, rd1, 0);
    chk({tag, "_wr"}, wr1, 0);
    chk({tag, "_lane"}, lane1, 0);
    chk({tag, "_i"}, i1, 0);
    chk({tag, "_j"}, j1, 0);
    chk({tag, "_round"}, round1, 0);
    chk({tag, "_last"}, last1, 0);
    chk({tag, "_state"}, st1, 0);
  endtask

  // One ROUNDS=1 sweep checked cycle by cycle; start is re-asserted at cycles s1/s2.
  task automatic run_sweep(input int s1, input int s2, input bit use_tbl);
    bit seen[5][5];
    int nrd;
    int n;
    nrd = 0;
    for (int a = 0; a < 5; a++)
      for (int b = 0; b < 5; b++) seen[a][b] = 1'b0;
    step(1'b1, 1'b0);
    for (int c = 1; c <= 52; c++) begin
      step((c == s1) || (c == s2), 1'b0);
      chk("sw_rd", rd1, (c <= 50) && (c % 2 == 1));
      chk("sw_wr", wr1, (c <= 50) && (c % 2 == 0));
      chk("sw_busy", busy1, c <= 50);
      chk("sw_done", done1, c == 51);
      chk("sw_last", last1, (c == 49) || (c == 50));
      if (c <= 50) begin
        n = (c - 1) / 2;
        chk("sw_lane", lane1, n);
        chk("sw_i", i1, (n % 5 + 3) % 5);
        chk("sw_j", j1, (n / 5 + 3) % 5);
      end
      if (rd1 === 1'b1) begin
        chk("map_lane", lane1, nrd);
        chk("map_i", i1, (nrd % 5 + 3) % 5);
        chk("map_j", j1, (nrd / 5 + 3) % 5);
        if (i1 < 5 && j1 < 5) begin
          chk("map_unique", seen[i1][j1], 0);
          seen[i1][j1] = 1'b1;
        end
        nrd++;
      end
      if (use_tbl) begin
        for (int k = 0; k < 11; k++) begin
          if (tbl[k].cyc == c) begin
            chk("tbl_rd", rd1, tbl[k].rd);
            chk("tbl_wr", wr1, tbl[k].wr);
            chk("tbl_busy", busy1, tbl[k].busy);
            chk("tbl_done", done1, tbl[k].done);
            chk("tbl_last", last1, tbl[k].last);
            if (tbl[k].lane >= 0) begin
              chk("tbl_lane", lane1, tbl[k].lane);
              chk("tbl_i", i1, tbl[k].ci);
              chk("tbl_j", j1, tbl[k].cj);
            end
          end
        end
      end
    end
    chk("map_count", nrd, 25);
  endtask

  task automatic run_stall();
    logic h;
    step(1'b1, 1'b0);
    for (int c = 1; c <= 60; c++) begin
      h = ((c >= 25) && (c <= 27)) || (c == 29) || (c == 30);
      step(1'b0, h);
      if (h) begin
        chk("st_rd_held", rd1, 0);
        chk("st_wr_held", wr1, 0);
        chk("st_lane_held", lane1, 12);
        chk("st_i_held", i1, 0);
        chk("st_j_held", j1, 0);
        chk("st_busy_held", busy1, 1);
      end
      if (c == 28) begin
        chk("st_rd_release", rd1, 1);
        chk("st_lane_release", lane1, 12);
      end
      if (c == 31) chk("st_wr_release", wr1, 1);
      if (c == 32) begin
        chk("st_rd_next", rd1, 1);
        chk("st_lane_next", lane1, 13);
      end
      if (c == 55) begin
        chk("st_wr_last", wr1, 1);
        chk("st_lane_last", lane1, 24);
      end
      chk("st_done", done1, c == 56);
      chk("st_busy", busy1, c <= 55);
    end
  endtask

  task automatic run_multi();
    step(1'b1, 1'b0);
    for (int c = 1; c <= 105; c++) begin
      step(1'b0, 1'b0);
      chk("mr_done", done2, c == 101);
      chk("mr_busy", busy2, c <= 100);
      if (c == 50) begin
        chk("mr_wr24", wr2, 1);
        chk("mr_lane24", lane2, 24);
        chk("mr_round0", round2, 0);
        chk("mr_last24", last2, 1);
      end
      if (c == 51) begin
        chk("mr_rd0", rd2, 1);
        chk("mr_lane0", lane2, 0);
        chk("mr_i0", i2, 3);
        chk("mr_j0", j2, 3);
        chk("mr_round1", round2, 1);
      end
      if (c == 101) chk("mr_round_done", round2, 1);
      if (c == 103) begin
        chk("mr_round_idle", round2, 1);
        chk("mr_state_idle", st2, 0);
      end
    end
  endtask

  task automatic run_reset_midop();
    step(1'b1, 1'b0);
    for (int c = 1; c <= 27; c++) step(1'b0, 1'b0);
    chk("rm_pre_lane", lane1, 13);
    chk("rm_pre_rd", rd1, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero1("rm_async");
    chk("rm_busy2", busy2, 0);
    @(posedge clk);
    #1;
    chk("rm_held_busy", busy1, 0);
    rst_n = 1'b1;
    #2;
    step(1'b0, 1'b0);
    chk("rm_no_done", done1, 0);
    chk("rm_idle", st1, 0);
    run_sweep(0, 0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0,  3, 3};
    tbl[1]  = '{2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0,  3, 3};
    tbl[2]  = '{3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1,  4, 3};
    tbl[3]  = '{5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2,  0, 3};
    tbl[4]  = '{15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7,  0, 4};
    tbl[5]  = '{21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10, 3, 0};
    tbl[6]  = '{48, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 23, 1, 2};
    tbl[7]  = '{49, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24, 2, 2};
    tbl[8]  = '{50, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 24, 2, 2};
    tbl[9]  = '{51, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, 0};
    tbl[10] = '{52, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 0};

    rst_n = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero1("reset");
    chk("reset_busy2", busy2, 0);
    chk("reset_round2", round2, 0);
    rst_n = 1'b1;
    #2;
    idle(3);

    run_sweep(0, 0, 1'b1);
    idle(60);
    run_sweep(10, 30, 1'b0);
    idle(60);
    run_stall();
    idle(60);
    run_multi();
    idle(10);
    run_reset_midop();
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_sweep_controller.md
Name: lane_sweep_controller

Overview:
- Sequences the 25-lane 5x5 state array for a lane-wise datapath, one lane per read/write pair, for a programmable number of rounds.
- Generates the lane index and its permuted (i, j) coordinates using the team's lane mapping: i = (n mod 5 + 3) mod 5, j = (n div 5 + 3) mod 5.
- Issues read and write strobes to the lane memory/datapath.
- Sits between the top-level start/done control and the lane memory.

Parameters:
- ROUNDS, 24, number of full 25-lane sweeps per start.
- ROUND_W, 5, width of the round output; must satisfy 2^ROUND_W >= ROUNDS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation; sampled only in IDLE
- hold  input  1  stall request; freezes sequencing while high
- busy  output  1  high from the first READ cycle through the last WRITE cycle
- done  output  1  one-cycle completion pulse
- rd_en  output  1  lane read strobe
- wr_en  output  1  lane write strobe
- lane_num  output  5  current linear lane index, 0..24
- i  output  3  mapped column coordinate, 0..4
- j  output  3  mapped row coordinate, 0..4
- round  output  ROUND_W  current round, 0..ROUNDS-1
- last_lane  output  1  high while lane_num==24 in READ or WRITE

Behaviour:
- Reset (async, rst_n low): state IDLE; lane_num, round, i, j = 0; busy, done, rd_en, wr_en, last_lane = 0. Takes effect immediately, including mid-sweep. No partial completion is signalled.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Outputs 0, i/j = 0.
  - start=1 at a clock edge -> READ next cycle, with lane_num=0, round=0.
- READ:
  - rd_en=1, busy=1.
  - If hold=0 -> WRITE.
  - If hold=1 -> remain in READ; rd_en forced 0 while hold is high; counters frozen.
- WRITE:
  - wr_en=1, busy=1. lane_num, i and j equal the values of the preceding READ.
  - If hold=1 -> remain in WRITE; wr_en forced 0; counters frozen.
  - If hold=0 and lane_num<24 -> lane_num+1, then READ.
  - If hold=0 and lane_num==24 and round<ROUNDS-1 -> lane_num=0, round+1, then READ.
  - If hold=0 and lane_num==24 and round==ROUNDS-1 -> DONE.
- DONE: done=1 and busy=0 for exactly one cycle -> IDLE. round holds ROUNDS-1 until the next start.
- Coordinate generation:
  - No divider. Internal column counter x and row counter y, both 0..4.
  - x increments each lane advance and wraps 4->0; y increments only on an x wrap and wraps 4->0.
  - Both are cleared at start and at each round boundary.
  - i = x+3 with wrap (x>=2 ? x-2 : x+3); same rule for j from y.
  - i/j are registered together with lane_num, so they are valid in the same cycle as rd_en/wr_en.
- start while busy or in DONE: ignored, no restart.
- hold in IDLE or DONE: no effect.
- Latency with no hold: the start edge is followed by the first READ in cycle 1. Each lane takes 2 cycles. done is high in cycle 50*ROUNDS+1 after the start edge.
- hold adds exactly one cycle per held cycle to the total latency.

Test Plan:
- Reset values: assert rst_n=0 mid-operation (lane 13, round 0) -> same cycle, all outputs 0, state IDLE; after release, a new start sweeps again from lane 0.
- Full sweep, ROUNDS=1: pulse start -> rd_en/wr_en alternate. Lane 0 gives (i,j)=(3,3), lane 1 (4,3), lane 2 (0,3), lane 7 (0,4), lane 10 (3,0), lane 24 (2,2). last_lane is high only during lane 24. done is high in cycle 51 only; busy is high in cycles 1..50.
- Mapping exhaustive: capture (lane_num, i, j) at every rd_en over one round -> all 25 entries match i=(n%5+3)%5, j=(n/5+3)%5. Each (i,j) pair appears exactly once.
- Stall: hold=1 for 3 cycles during lane 12 READ, and for 2 cycles during lane 12 WRITE -> no strobes while held; lane/(i,j)=(0,0) stays unchanged; done is delayed by 5 cycles (cycle 56 with ROUNDS=1).
- Multi-round, ROUNDS=2: after lane 24 WRITE of round 0 -> next READ shows lane 0, (3,3), round=1; done in cycle 101; round reads 1 at done.
- Start while busy: assert start at cycles 10 and 30 of a ROUNDS=1 sweep -> no restart, lane sequence unaffected, done still in cycle 51.
